mem_port_arbiter: RTL and testbench

Shares one single-ported, fixed-latency 64-bit memory between the instruction-fetch stage and the data-memory stage of the 5-stage pipelined CPU. It sequences each access through an issue/wait/complete state machine and buffers the fetched instruction word. It also generates the stall signals that freeze the pipeline registers while an access is outstanding. Data-stage requests win arbitration because they belong to the older instruction.

---
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the memory port arbiter and its environment: the
// fetch and data-stage request ports, the shared memory port and the
// pipeline stall lines.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_flush;
  logic        mem_rd;
  logic        mem_wr;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        port_en;
  logic        port_we;
  logic [63:0] port_addr;
  logic [63:0] port_wdata;
  logic [63:0] port_rdata;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        mem_done;
  logic [63:0] mem_rdata;
  logic        stall_back;
  logic        stall_front;

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, if_flush, mem_rd, mem_wr, mem_addr, mem_wdata,
    input  port_rdata,
    output port_en, port_we, port_addr, port_wdata,
    output if_valid, if_rdata, mem_done, mem_rdata, stall_back, stall_front
  );

  // Pipeline / memory side.
  modport master (
    output if_req, if_addr, if_flush, mem_rd, mem_wr, mem_addr, mem_wdata,
    output port_rdata,
    input  port_en, port_we, port_addr, port_wdata,
    input  if_valid, if_rdata, mem_done, mem_rdata, stall_back, stall_front
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency 64-bit memory port between instruction fetch
// and the data-memory stage. Data-stage requests win because they belong to
// the older instruction. Each access runs IDLE -> ISSUE -> (WAIT) -> DONE and
// is never preempted. The fetched 32-bit word is held in a one-entry buffer.
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned CW = $clog2(MEM_LAT) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

  state_e          state_q;
  owner_e          owner_q;
  logic [CW-1:0]   cnt_q;
  logic            discard_q;
  logic            port_en_q;
  logic            port_we_q;
  logic [63:0]     port_addr_q;
  logic [63:0]     port_wdata_q;
  logic            if_valid_q;
  logic [31:0]     if_rdata_q;
  logic            mem_done_q;
  logic [63:0]     mem_rdata_q;

  logic            mem_req_s;
  logic            stall_back_s;
  logic            stall_front_s;
  logic            if_grant_s;
  logic            if_flush_hit_s;

  // Request decode and stall generation; stalls stay live during reset
  // because every registered term is already 0 then.
  always_comb begin
    mem_req_s      = bus.mem_rd | bus.mem_wr;
    stall_back_s   = mem_req_s & ~mem_done_q;
    stall_front_s  = stall_back_s | (bus.if_req & ~if_valid_q);
    if_grant_s     = bus.if_req & ~if_valid_q & ~bus.if_flush;
    if_flush_hit_s = (owner_q == OWN_IF) & bus.if_flush;
  end

  // Access sequencer with registered port, fetch-buffer and load-data outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_IF;
      cnt_q        <= {CW{1'b0}};
      discard_q    <= 1'b0;
      port_en_q    <= 1'b0;
      port_we_q    <= 1'b0;
      port_addr_q  <= 64'h0;
      port_wdata_q <= 64'h0;
      if_valid_q   <= 1'b0;
      if_rdata_q   <= 32'h0;
      mem_done_q   <= 1'b0;
      mem_rdata_q  <= 64'h0;
    end else begin
      // Port strobes and the completion pulse last a single cycle.
      port_en_q  <= 1'b0;
      port_we_q  <= 1'b0;
      mem_done_q <= 1'b0;

      // A flush or a consumption by an unstalled IF/ID empties the buffer.
      if (bus.if_flush || (if_valid_q && !stall_back_s)) begin
        if_valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (mem_req_s) begin
            state_q      <= S_ISSUE;
            owner_q      <= OWN_MEM;
            port_en_q    <= 1'b1;
            port_we_q    <= bus.mem_wr;
            port_addr_q  <= bus.mem_addr;
            port_wdata_q <= bus.mem_wdata;
          end else if (if_grant_s) begin
            state_q     <= S_ISSUE;
            owner_q     <= OWN_IF;
            port_en_q   <= 1'b1;
            port_addr_q <= bus.if_addr;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_ISSUE: begin
          if (if_flush_hit_s) begin
            discard_q <= 1'b1;
          end
          if (port_we_q) begin
            state_q    <= S_DONE;
            mem_done_q <= (owner_q == OWN_MEM);
          end else begin
            state_q <= S_WAIT;
            cnt_q   <= CW'(MEM_LAT - 1);
          end
        end
        S_WAIT: begin
          if (if_flush_hit_s) begin
            discard_q <= 1'b1;
          end
          if (cnt_q == {CW{1'b0}}) begin
            state_q <= S_DONE;
            if (owner_q == OWN_MEM) begin
              mem_rdata_q <= bus.port_rdata;
              mem_done_q  <= 1'b1;
            end else if (!discard_q && !bus.if_flush) begin
              // Flush on the capture edge wins: the word is dropped.
              if_rdata_q <= port_addr_q[2] ? bus.port_rdata[63:32]
                                           : bus.port_rdata[31:0];
              if_valid_q <= 1'b1;
            end else begin
              if_valid_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_DONE: begin
          state_q   <= S_IDLE;
          discard_q <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.port_en     = port_en_q;
  assign bus.port_we     = port_we_q;
  assign bus.port_addr   = port_addr_q;
  assign bus.port_wdata  = port_wdata_q;
  assign bus.if_valid    = if_valid_q;
  assign bus.if_rdata    = if_rdata_q;
  assign bus.mem_done    = mem_done_q;
  assign bus.mem_rdata   = mem_rdata_q;
  assign bus.stall_back  = stall_back_s;
  assign bus.stall_front = stall_front_s;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LAT=2. Cycle 0 of each test
// is the cycle in which the request is first driven; inputs change 1 ns
// after a rising edge and outputs are sampled on the falling edge.
module tb_mem_port_arbiter;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.MEM_LAT(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: one fixed word plus a pattern derived from the address.
  function automatic logic [63:0] data_of(input logic [63:0] a);
    if (a == 64'h0C) return 64'h1111_2222_3333_4444;
    return {32'hC0DE_0000 | a[31:0], ~a[31:0]};
  endfunction

  // Two-stage read pipe: data for a read issued in cycle n is valid in n+2.
  logic [63:0] p0_a, p1_a;
  logic        p0_v, p1_v;
  always @(posedge clk) begin
    if (!reset) begin
      p0_v <= 1'b0;
      p1_v <= 1'b0;
    end else begin
      p0_v <= bus.port_en & ~bus.port_we;
      p0_a <= bus.port_addr;
      p1_v <= p0_v;
      p1_a <= p0_a;
    end
  end
  assign bus.port_rdata = p1_v ? data_of(p1_a) : 64'hBADC_0FFE_E0DD_F00D;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Fetch from 0x50, reset asserted mid-cycle in cycle rc, then re-issue.
  task automatic reset_fetch(input int rc);
    logic [63:0] w;
    w = data_of(64'h50);
    next_cycle();
    bus.if_req  = 1'b1;
    bus.if_addr = 64'h50;
    for (int c = 1; c <= rc; c++) next_cycle();
    #2;
    check_val("rst_pre_en", bus.port_en, (rc == 1));
    reset = 1'b0;
    #1;
    check_val("rst_en", bus.port_en, 64'h0);
    check_val("rst_ifv", bus.if_valid, 64'h0);
    check_val("rst_done", bus.mem_done, 64'h0);
    check_val("rst_sf", bus.stall_front, 64'h1);
    next_cycle();
    reset = 1'b1;
    sample();
    check_val("rel_en", bus.port_en, 64'h0);
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      if (c == 5) bus.if_req = 1'b0;
      sample();
      check_val("rel_en", bus.port_en, (c == 1));
      if (c == 1) check_val("rel_addr", bus.port_addr, 64'h50);
      check_val("rel_ifv", bus.if_valid, (c == 4));
      if (c == 4) check_val("rel_ird", bus.if_rdata, {32'h0, w[31:0]});
    end
  endtask

  initial begin
    logic [63:0] w;
    logic [63:0] w10;
    n_vec = 0;
    n_err = 0;
    reset         = 1'b0;
    bus.if_req    = 1'b0;
    bus.if_addr   = 64'h0;
    bus.if_flush  = 1'b0;
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = 64'h0;
    bus.mem_wdata = 64'h0;

    // Reset state and combinational stalls during reset.
    #2;
    check_val("rst_port_en", bus.port_en, 64'h0);
    check_val("rst_port_we", bus.port_we, 64'h0);
    check_val("rst_port_addr", bus.port_addr, 64'h0);
    check_val("rst_port_wdata", bus.port_wdata, 64'h0);
    check_val("rst_if_valid", bus.if_valid, 64'h0);
    check_val("rst_if_rdata", {32'h0, bus.if_rdata}, 64'h0);
    check_val("rst_mem_done", bus.mem_done, 64'h0);
    check_val("rst_mem_rdata", bus.mem_rdata, 64'h0);
    bus.mem_rd = 1'b1;
    #1;
    check_val("rst_sb_rd", bus.stall_back, 64'h1);
    check_val("rst_sf_rd", bus.stall_front, 64'h1);
    bus.mem_rd = 1'b0;
    bus.if_req = 1'b1;
    #1;
    check_val("rst_sb_if", bus.stall_back, 64'h0);
    check_val("rst_sf_if", bus.stall_front, 64'h1);
    bus.if_req = 1'b0;
    next_cycle();
    reset = 1'b1;

    // Fetch of 0x0C: upper half of the returned word.
    next_cycle();
    bus.if_req  = 1'b1;
    bus.if_addr = 64'h0C;
    sample();
    check_val("f_sf0", bus.stall_front, 64'h1);
    check_val("f_en0", bus.port_en, 64'h0);
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      if (c == 5) bus.if_req = 1'b0;
      sample();
      check_val("f_en", bus.port_en, (c == 1));
      if (c == 1) check_val("f_addr", bus.port_addr, 64'h0C);
      check_val("f_sf", bus.stall_front, (c <= 3));
      check_val("f_ifv", bus.if_valid, (c == 4));
      if (c == 4) check_val("f_ird", {32'h0, bus.if_rdata}, 64'h1111_2222);
    end

    // Simultaneous fetch and load: the load goes first.
    w   = data_of(64'h40);
    w10 = data_of(64'h10);
    next_cycle();
    bus.if_req   = 1'b1;
    bus.if_addr  = 64'h10;
    bus.mem_rd   = 1'b1;
    bus.mem_addr = 64'h40;
    for (int c = 1; c <= 10; c++) begin
      next_cycle();
      if (c == 5) bus.mem_rd = 1'b0;
      if (c == 10) bus.if_req = 1'b0;
      sample();
      check_val("s_en", bus.port_en, (c == 1 || c == 6));
      if (c == 1) check_val("s_addr1", bus.port_addr, 64'h40);
      if (c == 1) check_val("s_we1", bus.port_we, 64'h0);
      if (c == 6) check_val("s_addr6", bus.port_addr, 64'h10);
      check_val("s_done", bus.mem_done, (c == 4));
      check_val("s_sb", bus.stall_back, (c <= 3));
      check_val("s_ifv", bus.if_valid, (c == 9));
      if (c == 9) check_val("s_ird", {32'h0, bus.if_rdata}, {32'h0, w10[31:0]});
      if (c >= 4) check_val("s_mrd", bus.mem_rdata, w);
    end

    // Store: single-cycle write strobe, done one cycle later.
    next_cycle();
    bus.mem_wr    = 1'b1;
    bus.mem_addr  = 64'h80;
    bus.mem_wdata = 64'hDEAD_BEEF_0000_0001;
    sample();
    check_val("w_sb0", bus.stall_back, 64'h1);
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      if (c == 3) bus.mem_wr = 1'b0;
      sample();
      check_val("w_en", bus.port_en, (c == 1));
      check_val("w_we", bus.port_we, (c == 1));
      if (c == 1) check_val("w_addr", bus.port_addr, 64'h80);
      if (c == 1) check_val("w_data", bus.port_wdata, 64'hDEAD_BEEF_0000_0001);
      check_val("w_done", bus.mem_done, (c == 2));
      check_val("w_sb", bus.stall_back, (c == 1));
      check_val("w_mrd", bus.mem_rdata, w);
    end

    // Flush during an in-flight fetch; the refetch goes to the new address.
    w = data_of(64'h2C);
    next_cycle();
    bus.if_req  = 1'b1;
    bus.if_addr = 64'h20;
    for (int c = 1; c <= 10; c++) begin
      next_cycle();
      if (c == 2) begin
        bus.if_flush = 1'b1;
        bus.if_addr  = 64'h2C;
      end
      if (c == 3) bus.if_flush = 1'b0;
      if (c == 10) bus.if_req = 1'b0;
      sample();
      check_val("fl_en", bus.port_en, (c == 1 || c == 6));
      if (c == 6) check_val("fl_addr", bus.port_addr, 64'h2C);
      check_val("fl_ifv", bus.if_valid, (c == 9));
      if (c == 5) check_val("fl_keep", {32'h0, bus.if_rdata}, {32'h0, w10[31:0]});
      if (c == 9) check_val("fl_ird", {32'h0, bus.if_rdata}, {32'h0, w[63:32]});
    end

    // Fetched word held while a load stalls the back end.
    w   = data_of(64'h30);
    w10 = data_of(64'h48);
    next_cycle();
    bus.if_req  = 1'b1;
    bus.if_addr = 64'h30;
    for (int c = 1; c <= 10; c++) begin
      next_cycle();
      if (c == 1) begin
        bus.mem_rd   = 1'b1;
        bus.mem_addr = 64'h48;
      end
      if (c == 10) begin
        bus.mem_rd = 1'b0;
        bus.if_req = 1'b0;
      end
      sample();
      check_val("h_ifv", bus.if_valid, (c >= 4 && c <= 9));
      if (c >= 4 && c <= 9) check_val("h_ird", {32'h0, bus.if_rdata}, {32'h0, w[31:0]});
      check_val("h_en", bus.port_en, (c == 1 || c == 6));
      if (c == 6) check_val("h_addr", bus.port_addr, 64'h48);
      check_val("h_done", bus.mem_done, (c == 9));
      if (c == 9) check_val("h_mrd", bus.mem_rdata, w10);
    end

    // Reset in ISSUE and in WAIT of a fetch.
    reset_fetch(1);
    reset_fetch(2);

    // Reset during the DONE cycle of a store.
    next_cycle();
    bus.mem_wr    = 1'b1;
    bus.mem_addr  = 64'h88;
    bus.mem_wdata = 64'h0123_4567_89AB_CDEF;
    next_cycle();
    next_cycle();
    #2;
    check_val("rd_pre_done", bus.mem_done, 64'h1);
    reset = 1'b0;
    #1;
    check_val("rd_done", bus.mem_done, 64'h0);
    check_val("rd_sb", bus.stall_back, 64'h1);
    check_val("rd_addr", bus.port_addr, 64'h0);
    check_val("rd_wdata", bus.port_wdata, 64'h0);
    check_val("rd_mrd", bus.mem_rdata, 64'h0);
    next_cycle();
    bus.mem_wr = 1'b0;
    reset      = 1'b1;
    sample();
    check_val("rd_sb_rel", bus.stall_back, 64'h0);
    check_val("rd_en_rel", bus.port_en, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
